flash_insn_fetch: RTL and testbench
===================================

FLASH_INSN_FETCH -- requirements
Module: flash_insn_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, giving the instruction word address width.
REQ-002 SHALL have parameter WORD_BYTES, default 2, legal range 1..4, giving flash bytes per instruction word.
REQ-003 SHALL have parameter WAIT_STATES, default 1, legal range 0..7, giving extra cycles between driving fl_addr and sampling fl_dq.
REQ-004 SHALL have parameter FL_ADDR_W, default 22, giving the flash byte address width.
REQ-005 SHALL have parameter BASE, default 0, giving the flash byte offset of word 0.
REQ-006 SHALL have parameter PREFETCH, default 1; 0 disables the speculative next-word fetch.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 req_valid  in  1  fetch request.
REQ-010 req_addr  in  ADDR_W  instruction word address.
REQ-011 req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
REQ-012 rsp_valid  out  1  one-cycle pulse; rsp_data is valid for the current request.
REQ-013 rsp_data  out  8*WORD_BYTES  assembled word; held stable until the next rsp_valid.
REQ-014 hit  out  1  pulses with rsp_valid when the response came from the prefetch buffer.
REQ-015 fl_addr  out  FL_ADDR_W  flash byte address.
REQ-016 fl_dq  in  8  flash read data.
REQ-017 fl_ce_n, fl_oe_n  out  1 each  flash chip enable and output enable, both active-low.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 States SHALL be IDLE, FETCH, DONE and SPEC; req_ready SHALL be high only in IDLE and SPEC.
REQ-020 The flash byte address for word A, beat b SHALL be BASE + A*WORD_BYTES + b, truncated to FL_ADDR_W bits.
REQ-021 Each beat SHALL drive fl_addr for WAIT_STATES+1 cycles, then capture fl_dq into rsp_data[8b+7:8b], so byte 0 lands in the least-significant position.
REQ-022 fl_ce_n and fl_oe_n SHALL be low in FETCH and SPEC and high in IDLE and DONE.
REQ-023 A miss SHALL assert rsp_valid exactly WORD_BYTES*(WAIT_STATES+1)+1 cycles after the accepting edge (FETCH, then DONE).
REQ-024 A hit SHALL assert rsp_valid and hit exactly 1 cycle after the accepting edge, and SHALL copy pf_data into rsp_data. A hit requires pf_valid && req_addr==pf_addr.
REQ-025 When PREFETCH=1, leaving DONE (or completing a hit) SHALL enter SPEC and fetch word A+1 modulo 2^ADDR_W into the internal pf_data and pf_addr registers, then set pf_valid and return to IDLE.
REQ-026 When PREFETCH=0, DONE SHALL return to IDLE, pf_valid SHALL stay 0, and hit SHALL never assert.
REQ-027 A request accepted in SPEC whose address equals the in-flight address SHALL keep the current beat progress and respond when the fetch completes, with hit=0.
REQ-028 A request accepted in SPEC whose address differs SHALL abort the speculation immediately, clear pf_valid, and start a miss fetch from beat 0 on the next edge.
REQ-029 A new miss SHALL clear pf_valid; rsp_data SHALL remain at its old value until the new word's last beat is captured, and SHALL then update atomically.
REQ-030 The beat counter and wait counter SHALL be sized for WORD_BYTES and WAIT_STATES; no counter SHALL wrap mid-word.

Reset
REQ-031 While rst is high, state SHALL be IDLE, and outputs SHALL be rsp_valid=0, hit=0, rsp_data=0, fl_addr=0, fl_ce_n=1, fl_oe_n=1, busy=0, req_ready=1, pf_valid=0.
REQ-032 Reset asserted mid-fetch SHALL discard all partial data; the first request after release SHALL be a full miss.

Verification (WORD_BYTES=2, WAIT_STATES=1, BASE=0 unless stated)
REQ-033 Miss: flash[0x20]=0x34, flash[0x21]=0x12; request 0x0010 -> fl_addr shows 0x20 then 0x21, rsp_valid 5 cycles after accept, rsp_data=0x1234, hit=0.
REQ-034 Sequential hit: after REQ-033 and SPEC completion, flash[0x22..0x23]=0xCD,0xAB; request 0x0011 -> rsp_valid and hit 1 cycle later, rsp_data=0xABCD.
REQ-035 Abort: request 0x0040 issued during SPEC for 0x0011 -> pf_valid=0, fl_addr jumps to 0x80, response at 5 cycles, hit=0.
REQ-036 Wrap: request 0xFFFF, flash[0x0000..0x0001]=0x01,0x02 -> SPEC fetches word 0x0000; request 0x0000 -> hit, rsp_data=0x0201.
REQ-037 Reset mid-fetch: rst pulsed during beat 1 -> outputs match REQ-031; re-request 0x0010 -> full 5-cycle miss, rsp_data=0x1234.
REQ-038 Parameters: WORD_BYTES=4, WAIT_STATES=0, BASE=0x100; request 0x0002 -> fl_addr 0x108..0x10B, rsp_valid 5 cycles after accept, little-endian assembly.

Source files
------------

// File: rtl/flash_insn_fetch.sv
// rtl/flash_insn_fetch.sv - instruction fetch from byte-wide parallel flash with one-word prefetch
// A word is assembled beat by beat; after each response the next sequential word is prefetched.
module flash_insn_fetch #(
  parameter int ADDR_W      = 16,
  parameter int WORD_BYTES  = 2,
  parameter int WAIT_STATES = 1,
  parameter int FL_ADDR_W   = 22,
  parameter int BASE        = 0,
  parameter int PREFETCH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_data,
  output logic                    hit,
  output logic [FL_ADDR_W-1:0]    fl_addr,
  input  logic [7:0]              fl_dq,
  output logic                    fl_ce_n,
  output logic                    fl_oe_n,
  output logic                    busy
);

  localparam int DW     = 8 * WORD_BYTES;
  localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int BEAT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE, SPEC} state_t;

  state_t                r_state;
  logic [WAIT_W-1:0]     r_wait;
  logic [BEAT_W-1:0]     r_beat;
  logic [ADDR_W-1:0]     r_cur;
  logic [ADDR_W-1:0]     r_pf_addr;
  logic [DW-1:0]         r_buf;
  logic [DW-1:0]         r_pf_data;
  logic [DW-1:0]         r_rsp_data;
  logic                  r_pf_valid;
  logic                  r_rsp_valid;
  logic                  r_hit;
  logic                  r_is_hit;
  logic [FL_ADDR_W-1:0]  r_fl_addr;

  logic [DW-1:0]         w_word;
  logic                  w_cap;
  logic                  w_last;
  logic                  w_hit;
  logic [ADDR_W-1:0]     w_next;

  function automatic logic [FL_ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] a);
    return FL_ADDR_W'(BASE) + FL_ADDR_W'(a) * FL_ADDR_W'(WORD_BYTES);
  endfunction

  // Current buffer with the byte being captured this cycle merged in.
  always_comb begin
    w_word = r_buf;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (r_beat == BEAT_W'(b)) w_word[8*b +: 8] = fl_dq;
    end
  end

  assign w_cap  = (r_wait == WAIT_W'(WAIT_STATES));
  assign w_last = w_cap && (r_beat == BEAT_W'(WORD_BYTES - 1));
  assign w_hit  = (PREFETCH != 0) && r_pf_valid && (req_addr == r_pf_addr);
  assign w_next = r_cur + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_beat      <= '0;
      r_cur       <= '0;
      r_pf_addr   <= '0;
      r_buf       <= '0;
      r_pf_data   <= '0;
      r_rsp_data  <= '0;
      r_pf_valid  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_is_hit    <= 1'b0;
      r_fl_addr   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_hit       <= 1'b0;
      if (r_state == FETCH || r_state == SPEC) begin
        if (w_cap) begin
          r_buf  <= w_word;
          r_wait <= '0;
          if (!w_last) begin
            r_beat    <= r_beat + BEAT_W'(1);
            r_fl_addr <= r_fl_addr + FL_ADDR_W'(1);
          end
        end else begin
          r_wait <= r_wait + WAIT_W'(1);
        end
      end
      case (r_state)
        IDLE: if (req_valid) begin
          r_cur <= req_addr;
          if (w_hit) begin
            r_is_hit <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_is_hit   <= 1'b0;
            r_pf_valid <= 1'b0;
            r_fl_addr  <= byte_addr(req_addr);
            r_wait     <= '0;
            r_beat     <= '0;
            r_state    <= FETCH;
          end
        end
        FETCH: if (w_last) r_state <= DONE;
        DONE: begin
          r_rsp_valid <= 1'b1;
          r_hit       <= r_is_hit;
          r_rsp_data  <= r_is_hit ? r_pf_data : r_buf;
          if (PREFETCH != 0) begin
            r_cur      <= w_next;
            r_pf_valid <= 1'b0;
            r_fl_addr  <= byte_addr(w_next);
            r_wait     <= '0;
            r_beat     <= '0;
            r_state    <= SPEC;
          end else begin
            r_state <= IDLE;
          end
        end
        SPEC: begin
          if (req_valid && req_addr != r_cur) begin
            r_cur     <= req_addr;
            r_is_hit  <= 1'b0;
            r_fl_addr <= byte_addr(req_addr);
            r_wait    <= '0;
            r_beat    <= '0;
            r_state   <= FETCH;
          end else if (req_valid) begin
            // Demand for the word already in flight: keep beat progress.
            r_is_hit <= 1'b0;
            r_state  <= w_last ? DONE : FETCH;
          end else if (w_last) begin
            r_pf_data  <= w_word;
            r_pf_addr  <= r_cur;
            r_pf_valid <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) || (r_state == SPEC);
  assign busy      = (r_state != IDLE);
  assign fl_ce_n   = !((r_state == FETCH) || (r_state == SPEC));
  assign fl_oe_n   = fl_ce_n;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign hit       = r_hit;
  assign fl_addr   = r_fl_addr;

endmodule

// File: tb/tb_flash_insn_fetch.sv
// tb/tb_flash_insn_fetch.sv - directed self-checking bench for flash_insn_fetch
// Two instances share one flash image: default parameters and a 4-byte, zero-wait variant.
module tb_flash_insn_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic        req_ready, rsp_valid, hit, fl_ce_n, fl_oe_n, busy;
  logic [15:0] rsp_data;
  logic [21:0] fl_addr;
  logic [7:0]  fl_dq;

  logic        req_valid2 = 1'b0;
  logic [15:0] req_addr2 = '0;
  logic        req_ready2, rsp_valid2, hit2, fl_ce_n2, fl_oe_n2, busy2;
  logic [31:0] rsp_data2;
  logic [21:0] fl_addr2;
  logic [7:0]  fl_dq2;

  logic [7:0] mem [0:131071];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign fl_dq  = mem[fl_addr[16:0]];
  assign fl_dq2 = mem[fl_addr2[16:0]];

  flash_insn_fetch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .hit(hit),
    .fl_addr(fl_addr), .fl_dq(fl_dq), .fl_ce_n(fl_ce_n), .fl_oe_n(fl_oe_n), .busy(busy)
  );

  flash_insn_fetch #(.WORD_BYTES(4), .WAIT_STATES(0), .BASE(32'h100)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_addr(req_addr2),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .hit(hit2),
    .fl_addr(fl_addr2), .fl_dq(fl_dq2), .fl_ce_n(fl_ce_n2), .fl_oe_n(fl_oe_n2), .busy(busy2)
  );

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b required 0", busy); end
  endtask

  // Issues one request and reports latency (-1 on timeout), data, hit, and fl_addr/pf_valid just after accept.
  task automatic do_req(input logic [15:0] a, output int lat, output logic [15:0] d,
                        output logic h, output logic [21:0] fa, output logic pfv);
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    fa = fl_addr; pfv = dut.r_pf_valid;
    lat = -1; d = 'x; h = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin lat = i; d = rsp_data; h = hit; break; end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, hit, rsp_data, fl_addr, fl_ce_n, fl_oe_n, busy, req_ready, dut.r_pf_valid} !==
        {1'b0, 1'b0, 16'h0, 22'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: v=%b h=%b d=%h a=%h ce=%b oe=%b busy=%b rdy=%b pf=%b required 0 0 0 0 1 1 0 1 0",
               rsp_valid, hit, rsp_data, fl_addr, fl_ce_n, fl_oe_n, busy, req_ready, dut.r_pf_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_miss();
    req_valid = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({fl_addr, fl_ce_n, fl_oe_n, req_ready, busy} !== {22'h20, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL miss_beat0: a=%h ce=%b oe=%b rdy=%b busy=%b required 20 0 0 0 1",
               fl_addr, fl_ce_n, fl_oe_n, req_ready, busy);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (fl_addr !== 22'h21) begin errors++; $display("FAIL miss_beat1: fl_addr=%h required 21", fl_addr); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({rsp_valid, fl_ce_n, rsp_data} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL miss_done: v=%b ce=%b d=%h required 0 1 0000", rsp_valid, fl_ce_n, rsp_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, hit, rsp_data} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL miss_rsp: v=%b h=%b d=%h required 1 0 1234", rsp_valid, hit, rsp_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_data, fl_addr, fl_ce_n} !== {1'b0, 16'h1234, 22'h22, 1'b0}) begin
      errors++;
      $display("FAIL miss_spec: v=%b d=%h a=%h ce=%b required 0 1234 22 0", rsp_valid, rsp_data, fl_addr, fl_ce_n);
    end
  endtask

  task automatic test_hit();
    int lat; logic [15:0] d; logic h; logic [21:0] fa; logic pfv;
    wait_idle();
    checks++;
    if ({dut.r_pf_valid, dut.r_pf_addr} !== {1'b1, 16'h0011}) begin
      errors++; $display("FAIL pf_fill: pf_valid=%b pf_addr=%h required 1 0011", dut.r_pf_valid, dut.r_pf_addr);
    end
    do_req(16'h0011, lat, d, h, fa, pfv);
    checks++;
    if (lat !== 1 || h !== 1'b1 || d !== 16'hABCD) begin
      errors++; $display("FAIL seq_hit: lat=%0d hit=%b d=%h required 1 1 abcd", lat, h, d);
    end
  endtask

  task automatic test_same_addr_spec();
    int lat; logic [15:0] d; logic h; logic [21:0] fa; logic pfv;
    wait_idle();
    do_req(16'h0010, lat, d, h, fa, pfv);
    checks++;
    if (lat !== 5 || h !== 1'b0 || d !== 16'h1234) begin
      errors++; $display("FAIL miss_again: lat=%0d hit=%b d=%h required 5 0 1234", lat, h, d);
    end
    do_req(16'h0011, lat, d, h, fa, pfv);
    checks++;
    if (lat !== 4 || h !== 1'b0 || d !== 16'hABCD) begin
      errors++; $display("FAIL spec_join: lat=%0d hit=%b d=%h required 4 0 abcd", lat, h, d);
    end
  endtask

  task automatic test_abort();
    int lat; logic [15:0] d; logic h; logic [21:0] fa; logic pfv;
    wait_idle();
    do_req(16'h0010, lat, d, h, fa, pfv);
    do_req(16'h0040, lat, d, h, fa, pfv);
    checks++;
    if (fa !== 22'h80 || pfv !== 1'b0) begin
      errors++; $display("FAIL abort_jump: fl_addr=%h pf_valid=%b required 80 0", fa, pfv);
    end
    checks++;
    if (lat !== 5 || h !== 1'b0 || d !== 16'h7F5E) begin
      errors++; $display("FAIL abort_rsp: lat=%0d hit=%b d=%h required 5 0 7f5e", lat, h, d);
    end
    wait_idle();
    do_req(16'h0011, lat, d, h, fa, pfv);
    checks++;
    if (lat !== 5 || h !== 1'b0 || d !== 16'hABCD) begin
      errors++; $display("FAIL after_abort_miss: lat=%0d hit=%b d=%h required 5 0 abcd", lat, h, d);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] d; logic h; logic [21:0] fa; logic pfv;
    wait_idle();
    do_req(16'hFFFF, lat, d, h, fa, pfv);
    checks++;
    if (fa !== 22'h1FFFE || lat !== 5 || d !== 16'hA55A) begin
      errors++; $display("FAIL wrap_miss: a=%h lat=%0d d=%h required 1fffe 5 a55a", fa, lat, d);
    end
    wait_idle();
    do_req(16'h0000, lat, d, h, fa, pfv);
    checks++;
    if (lat !== 1 || h !== 1'b1 || d !== 16'h0201) begin
      errors++; $display("FAIL wrap_hit: lat=%0d hit=%b d=%h required 1 1 0201", lat, h, d);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] d; logic h; logic [21:0] fa; logic pfv;
    wait_idle();
    req_valid = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, hit, rsp_data, fl_addr, fl_ce_n, fl_oe_n, busy, req_ready, dut.r_pf_valid} !==
        {1'b0, 1'b0, 16'h0, 22'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: v=%b h=%b d=%h a=%h ce=%b oe=%b busy=%b rdy=%b pf=%b required 0 0 0 0 1 1 0 1 0",
               rsp_valid, hit, rsp_data, fl_addr, fl_ce_n, fl_oe_n, busy, req_ready, dut.r_pf_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(16'h0010, lat, d, h, fa, pfv);
    checks++;
    if (fa !== 22'h20 || lat !== 5 || h !== 1'b0 || d !== 16'h1234) begin
      errors++; $display("FAIL reset_rereq: a=%h lat=%0d hit=%b d=%h required 20 5 0 1234", fa, lat, h, d);
    end
  endtask

  task automatic test_params();
    int lat;
    req_valid2 = 1'b1; req_addr2 = 16'h0002;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    checks++;
    if (fl_addr2 !== 22'h108) begin errors++; $display("FAIL p4_beat0: fl_addr=%h required 108", fl_addr2); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (fl_addr2 !== 22'h10B) begin errors++; $display("FAIL p4_beat3: fl_addr=%h required 10b", fl_addr2); end
    lat = 3;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; lat++;
      if (rsp_valid2) break;
    end
    checks++;
    if (rsp_valid2 !== 1'b1 || lat !== 5 || hit2 !== 1'b0 || rsp_data2 !== 32'h44332211) begin
      errors++; $display("FAIL p4_rsp: v=%b lat=%0d hit=%b d=%h required 1 5 0 44332211", rsp_valid2, lat, hit2, rsp_data2);
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h00020] = 8'h34; mem[17'h00021] = 8'h12;
    mem[17'h00022] = 8'hCD; mem[17'h00023] = 8'hAB;
    mem[17'h00080] = 8'h5E; mem[17'h00081] = 8'h7F;
    mem[17'h1FFFE] = 8'h5A; mem[17'h1FFFF] = 8'hA5;
    mem[17'h00000] = 8'h01; mem[17'h00001] = 8'h02;
    mem[17'h00108] = 8'h11; mem[17'h00109] = 8'h22;
    mem[17'h0010A] = 8'h33; mem[17'h0010B] = 8'h44;
    repeat (2) @(posedge clk);
    test_reset();
    test_miss();
    test_hit();
    test_same_addr_spec();
    test_abort();
    test_wrap();
    test_reset_mid();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
